// File: rtl/axis_spm_offset_slew.sv
// axis_spm_offset_slew
// N-channel rate-limited offset generator for the SPM control path. Each
// channel output is its AXIS input plus a slewed absolute offset, plus the
// SC lock-in modulation if that channel is selected. The sum saturates to
// symmetric Q31 full scale. A ramp/settle FSM reports per-channel arrival,
// a busy flag and a one-clock settled pulse, so the scan controller can wait
// for an offset move to complete.
//
// Ports:
//   a_clk, a_resetn     clock, asynchronous active-low reset
//   config_addr/data    config bus, level-sampled while config_addr == reg_address
//   S_AXIS_IN_tdata     channel inputs, channel k at [k*DW +: DW]
//   S_AXIS_IN_tvalid    unused (the stream is always valid)
//   S_AXIS_SREF_tdata   SC reference, bits [SREF_DATA_WIDTH-1:0] used
//   M_AXIS_OUT_tdata    saturated channel outputs, updated on each tick
//   M_AXIS_OUT_tvalid   high from the first tick after reset
//   M_AXIS_MON_tdata    current slewed offsets
//   arrived             per-channel cur == target
//   busy                FSM not idle
//   settled             one-clock pulse when the move has settled
module axis_spm_offset_slew #(
  parameter int          NCH             = 4,
  parameter int          DW              = 32,
  parameter int          RDECI           = 5,
  parameter int          SETTLE_TICKS    = 16,
  parameter int          SREF_DATA_WIDTH = 25,
  parameter logic [31:0] reg_address     = 32'd1110
) (
  input  logic                a_clk,
  input  logic                a_resetn,
  input  logic [31:0]         config_addr,
  input  logic [511:0]        config_data,
  input  logic [NCH*DW-1:0]   S_AXIS_IN_tdata,
  input  logic                S_AXIS_IN_tvalid,
  input  logic [31:0]         S_AXIS_SREF_tdata,
  output logic [NCH*DW-1:0]   M_AXIS_OUT_tdata,
  output logic                M_AXIS_OUT_tvalid,
  output logic [NCH*DW-1:0]   M_AXIS_MON_tdata,
  output logic [NCH-1:0]      arrived,
  output logic                busy,
  output logic                settled
);

  localparam int PW   = 2 * SREF_DATA_WIDTH;   // modulation product width
  localparam int MW   = PW - 17;               // product >>> 17
  localparam int SW   = DW + 3;                // output sum width
  localparam int CNTW = (SETTLE_TICKS > 1) ? $clog2(SETTLE_TICKS) : 1;

  // Symmetric clamp limits: +/-(2^(DW-1)-1), in DW+1 and DW+3 bits.
  localparam logic signed [DW:0]   CUR_MAX = {2'b00, {(DW-1){1'b1}}};
  localparam logic signed [DW:0]   CUR_MIN = {2'b11, {(DW-2){1'b0}}, 1'b1};
  localparam logic signed [SW-1:0] SUM_MAX = {4'b0000, {(DW-1){1'b1}}};
  localparam logic signed [SW-1:0] SUM_MIN = {4'b1111, {(DW-2){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RAMP   = 2'd1,
    ST_SETTLE = 2'd2
  } state_t;

  logic [NCH-1:0][DW-1:0]         target_r;
  logic [NCH-1:0][DW-1:0]         cur_r;
  logic [NCH-1:0][DW-1:0]         out_r;
  logic [NCH-1:0][DW-1:0]         nxt_s;
  logic [NCH-1:0][DW-1:0]         sat_s;
  logic [30:0]                    step_r;
  logic                           freeze_r;
  logic [3:0]                     mod_sel_r;
  logic [SREF_DATA_WIDTH-1:0]     vol_r;
  logic signed [MW-1:0]           mod_r;
  logic signed [PW-1:0]           prod_s;
  logic [RDECI-1:0]               rdecii_r;
  logic                           tick_s;
  logic                           all_arrived_s;
  logic                           tvalid_r;
  state_t                         state_r;
  logic [CNTW-1:0]                settle_cnt_r;
  logic                           busy_r;
  logic                           settled_r;
  logic                           unused_s;

  assign tick_s        = (rdecii_r == RDECI'(0));
  assign all_arrived_s = &arrived;
  assign prod_s        = $signed(vol_r) * $signed(S_AXIS_SREF_tdata[SREF_DATA_WIDTH-1:0]);

  // Bits of the config/reference buses that carry no function here.
  assign unused_s = ^{S_AXIS_IN_tvalid, config_data, S_AXIS_SREF_tdata, prod_s[16:0]};

  // Config registers: reloaded every clock while the address matches.
  always_ff @(posedge a_clk or negedge a_resetn) begin
    if (!a_resetn) begin
      target_r  <= '0;
      step_r    <= 31'd0;
      freeze_r  <= 1'b0;
      mod_sel_r <= 4'd0;
      vol_r     <= {SREF_DATA_WIDTH{1'b0}};
    end else if (config_addr == reg_address) begin
      for (int k = 0; k < NCH; k++) begin
        target_r[k] <= config_data[k*32 +: DW];
      end
      step_r    <= config_data[NCH*32 +: 31];
      freeze_r  <= config_data[(NCH+1)*32];
      mod_sel_r <= config_data[(NCH+1)*32 + 4 +: 4];
      vol_r     <= config_data[(NCH+2)*32 + 32 - SREF_DATA_WIDTH +: SREF_DATA_WIDTH];
    end else begin
      target_r  <= target_r;
      step_r    <= step_r;
      freeze_r  <= freeze_r;
      mod_sel_r <= mod_sel_r;
      vol_r     <= vol_r;
    end
  end

  for (genvar k = 0; k < NCH; k++) begin : gen_ch
    logic signed [DW:0]   cur_e;
    logic signed [DW:0]   tgt_e;
    logic signed [DW:0]   step_e;
    logic signed [DW:0]   up_s;
    logic signed [DW:0]   dn_s;
    logic signed [DW:0]   upc_s;
    logic signed [DW:0]   dnc_s;
    logic signed [DW:0]   nxt_e;
    logic signed [SW-1:0] mod_e;
    logic signed [SW-1:0] sum_s;
    logic signed [SW-1:0] satc_s;

    assign cur_e  = (DW+1)'($signed(cur_r[k]));
    assign tgt_e  = (DW+1)'($signed(target_r[k]));
    assign step_e = (DW+1)'(step_r);
    assign up_s   = cur_e + step_e;
    assign dn_s   = cur_e - step_e;

    // Slew one step toward the target; snap to it once within one step.
    always_comb begin
      upc_s = up_s;
      dnc_s = dn_s;
      nxt_e = cur_e;
      if (up_s > CUR_MAX) upc_s = CUR_MAX;
      else                upc_s = up_s;
      if (dn_s < CUR_MIN) dnc_s = CUR_MIN;
      else                dnc_s = dn_s;
      if (freeze_r)           nxt_e = cur_e;
      else if (tgt_e > upc_s) nxt_e = upc_s;
      else if (tgt_e < dnc_s) nxt_e = dnc_s;
      else                    nxt_e = tgt_e;
    end

    assign mod_e = (mod_sel_r == 4'(k + 1)) ? SW'(mod_r) : {SW{1'b0}};
    assign sum_s = SW'($signed(S_AXIS_IN_tdata[k*DW +: DW])) + SW'($signed(cur_r[k])) + mod_e;

    // Output saturation to symmetric full scale.
    always_comb begin
      satc_s = sum_s;
      if (sum_s > SUM_MAX)      satc_s = SUM_MAX;
      else if (sum_s < SUM_MIN) satc_s = SUM_MIN;
      else                      satc_s = sum_s;
    end

    assign nxt_s[k]   = nxt_e[DW-1:0];
    assign sat_s[k]   = satc_s[DW-1:0];
    assign arrived[k] = (cur_r[k] == target_r[k]);
  end

  // Tick counter and the tick-rate datapath: offsets, modulation, outputs.
  // Outputs use the pre-update offset and modulation.
  always_ff @(posedge a_clk or negedge a_resetn) begin
    if (!a_resetn) begin
      rdecii_r <= RDECI'(0);
      cur_r    <= '0;
      out_r    <= '0;
      mod_r    <= {MW{1'b0}};
      tvalid_r <= 1'b0;
    end else begin
      rdecii_r <= rdecii_r + RDECI'(1);
      if (tick_s) begin
        cur_r    <= nxt_s;
        out_r    <= sat_s;
        mod_r    <= prod_s[PW-1:17];
        tvalid_r <= 1'b1;
      end else begin
        cur_r    <= cur_r;
        out_r    <= out_r;
        mod_r    <= mod_r;
        tvalid_r <= tvalid_r;
      end
    end
  end

  // Ramp/settle FSM; busy and settled are registered with the state, so
  // busy falls in the same clock that settled pulses.
  always_ff @(posedge a_clk or negedge a_resetn) begin
    if (!a_resetn) begin
      state_r      <= ST_IDLE;
      settle_cnt_r <= CNTW'(0);
      busy_r       <= 1'b0;
      settled_r    <= 1'b0;
    end else begin
      settled_r <= 1'b0;
      if (tick_s) begin
        case (state_r)
          ST_IDLE: begin
            if (!all_arrived_s) begin
              state_r <= ST_RAMP;
              busy_r  <= 1'b1;
            end
          end
          ST_RAMP: begin
            if (all_arrived_s) begin
              state_r      <= ST_SETTLE;
              settle_cnt_r <= CNTW'(0);
            end
          end
          ST_SETTLE: begin
            if (!all_arrived_s) begin
              state_r <= ST_RAMP;
            end else if (settle_cnt_r == CNTW'(SETTLE_TICKS - 1)) begin
              state_r   <= ST_IDLE;
              busy_r    <= 1'b0;
              settled_r <= 1'b1;
            end else begin
              settle_cnt_r <= settle_cnt_r + CNTW'(1);
            end
          end
          default: begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign M_AXIS_OUT_tdata  = out_r;
  assign M_AXIS_OUT_tvalid = tvalid_r;
  assign M_AXIS_MON_tdata  = cur_r;
  assign busy              = busy_r;
  assign settled           = settled_r;

endmodule

// File: tb/tb_axis_spm_offset_slew.sv
module tb_axis_spm_offset_slew;
  localparam int NCH = 4;
  localparam int DW  = 32;

  logic               a_clk = 1'b0;
  logic               a_resetn;
  logic [31:0]        config_addr;
  logic [511:0]       config_data;
  logic [NCH*DW-1:0]  in_d;
  logic               in_v;
  logic [31:0]        sref;
  logic [NCH*DW-1:0]  out_d;
  logic               out_v;
  logic [NCH*DW-1:0]  mon_d;
  logic [NCH-1:0]     arrived;
  logic               busy;
  logic               settled;

  axis_spm_offset_slew #(
    .NCH(NCH), .DW(DW), .RDECI(2), .SETTLE_TICKS(16),
    .SREF_DATA_WIDTH(25), .reg_address(32'd1110)
  ) dut (
    .a_clk(a_clk), .a_resetn(a_resetn),
    .config_addr(config_addr), .config_data(config_data),
    .S_AXIS_IN_tdata(in_d), .S_AXIS_IN_tvalid(in_v),
    .S_AXIS_SREF_tdata(sref),
    .M_AXIS_OUT_tdata(out_d), .M_AXIS_OUT_tvalid(out_v),
    .M_AXIS_MON_tdata(mon_d),
    .arrived(arrived), .busy(busy), .settled(settled)
  );

  always #5 a_clk = ~a_clk;

  typedef struct {
    int          tag;
    logic [31:0] o0, o1, o2, m0;
    logic [3:0]  arr;
    logic        busy, settled;
  } exp_t;

  exp_t        sbq[$];
  exp_t        e;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] w [16];

  // Tick reference: a tick every 4 clocks, first one on the first edge after reset.
  logic [1:0] tcnt;
  int         tick_idx = 0;
  int         last_seen = 0;

  always @(posedge a_clk or negedge a_resetn) begin
    if (!a_resetn) tcnt <= 2'd0;
    else begin
      if (tcnt == 2'd0) tick_idx <= tick_idx + 1;
      tcnt <= tcnt + 2'd1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: after every tick edge, compare the DUT against the queued entry.
  always @(negedge a_clk) begin
    if (tick_idx != last_seen) begin
      last_seen = tick_idx;
      while (sbq.size() > 0 && sbq[0].tag <= tick_idx) begin
        e = sbq.pop_front();
        if (e.tag < tick_idx) begin
          checks++; errors++;
          $display("FAIL stale_entry: tick %0d expected at tick %0d", tick_idx, e.tag);
        end else begin
          chk($sformatf("out0@%0d", e.tag), out_d[0*32 +: 32], e.o0);
          chk($sformatf("out1@%0d", e.tag), out_d[1*32 +: 32], e.o1);
          chk($sformatf("out2@%0d", e.tag), out_d[2*32 +: 32], e.o2);
          chk($sformatf("mon0@%0d", e.tag), mon_d[0*32 +: 32], e.m0);
          chk($sformatf("arrived@%0d", e.tag), {28'd0, arrived}, {28'd0, e.arr});
          chk($sformatf("busy@%0d", e.tag), {31'd0, busy}, {31'd0, e.busy});
          chk($sformatf("settled@%0d", e.tag), {31'd0, settled}, {31'd0, e.settled});
          chk($sformatf("tvalid@%0d", e.tag), {31'd0, out_v}, 32'd1);
        end
      end
    end
  end

  task automatic apply_cfg();
    for (int i = 0; i < 16; i++) config_data[i*32 +: 32] = w[i];
  endtask

  task automatic next_tick();
    int start;
    int n;
    start = tick_idx;
    n = 0;
    while (tick_idx == start && n < 20) begin
      @(negedge a_clk);
      n++;
    end
    if (tick_idx == start) begin
      checks++; errors++;
      $display("FAIL tick_timeout: no tick after tick %0d", start);
    end
  endtask

  // Queue the expected state after the next tick, then wait for that tick.
  task automatic t(input logic [31:0] o0, input logic [31:0] o1, input logic [31:0] o2,
                   input logic [31:0] m0, input logic [3:0] arr,
                   input logic bz, input logic st);
    exp_t x;
    x.tag = tick_idx + 1;
    x.o0 = o0; x.o1 = o1; x.o2 = o2; x.m0 = m0;
    x.arr = arr; x.busy = bz; x.settled = st;
    sbq.push_back(x);
    next_tick();
  endtask

  task automatic chk_reset_state();
    chk("rst_out0", out_d[0*32 +: 32], 32'd0);
    chk("rst_out1", out_d[1*32 +: 32], 32'd0);
    chk("rst_mon0", mon_d[0*32 +: 32], 32'd0);
    chk("rst_tvalid", {31'd0, out_v}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_settled", {31'd0, settled}, 32'd0);
    chk("rst_arrived", {28'd0, arrived}, 32'h0000000F);
  endtask

  localparam logic [31:0] IN1  = 32'd2000;
  localparam logic [31:0] IN2  = 32'hFFFFFFFB;
  localparam logic [31:0] SAT  = 32'h7FFFFFFF;

  initial begin
    a_resetn = 1'b0;
    config_addr = 32'd1110;
    in_v = 1'b1;
    sref = 32'd0;
    for (int i = 0; i < 16; i++) w[i] = 32'd0;
    apply_cfg();
    in_d = '0;
    in_d[0*32 +: 32] = 32'd1000;
    in_d[1*32 +: 32] = IN1;
    in_d[2*32 +: 32] = IN2;
    repeat (2) @(negedge a_clk);
    #1 chk_reset_state();
    @(negedge a_clk);
    a_resetn = 1'b1;

    // Idle with all config zero.
    t(32'd1000, IN1, IN2, 32'd0, 4'hF, 1'b0, 1'b0);

    // Ramp channel 0 to 100 in steps of 32, then settle.
    w[0] = 32'd100; w[4] = 32'd32; apply_cfg();
    t(32'd1000, IN1, IN2, 32'd32,  4'hE, 1'b1, 1'b0);
    t(32'd1032, IN1, IN2, 32'd64,  4'hE, 1'b1, 1'b0);
    t(32'd1064, IN1, IN2, 32'd96,  4'hE, 1'b1, 1'b0);
    t(32'd1096, IN1, IN2, 32'd100, 4'hF, 1'b1, 1'b0);
    t(32'd1100, IN1, IN2, 32'd100, 4'hF, 1'b1, 1'b0);
    for (int i = 0; i < 15; i++) t(32'd1100, IN1, IN2, 32'd100, 4'hF, 1'b1, 1'b0);
    t(32'd1100, IN1, IN2, 32'd100, 4'hF, 1'b0, 1'b1);

    // New target 300, freeze for two ticks mid-ramp.
    w[0] = 32'd300; apply_cfg();
    t(32'd1100, IN1, IN2, 32'd132, 4'hE, 1'b1, 1'b0);
    t(32'd1132, IN1, IN2, 32'd164, 4'hE, 1'b1, 1'b0);
    w[5] = 32'd1; apply_cfg();
    t(32'd1164, IN1, IN2, 32'd164, 4'hE, 1'b1, 1'b0);
    t(32'd1164, IN1, IN2, 32'd164, 4'hE, 1'b1, 1'b0);
    w[5] = 32'd0; apply_cfg();
    t(32'd1164, IN1, IN2, 32'd196, 4'hE, 1'b1, 1'b0);
    t(32'd1196, IN1, IN2, 32'd228, 4'hE, 1'b1, 1'b0);
    t(32'd1228, IN1, IN2, 32'd260, 4'hE, 1'b1, 1'b0);
    t(32'd1260, IN1, IN2, 32'd292, 4'hE, 1'b1, 1'b0);
    t(32'd1292, IN1, IN2, 32'd300, 4'hF, 1'b1, 1'b0);
    t(32'd1300, IN1, IN2, 32'd300, 4'hF, 1'b1, 1'b0);

    // Modulation on channel 1: 0x800000 * 0x800000 >>> 17 = 0x20000000.
    w[6] = 32'h40000000; w[5] = 32'h00000020; apply_cfg();
    sref = 32'h00800000;
    t(32'd1300, IN1,          IN2, 32'd300, 4'hF, 1'b1, 1'b0);
    t(32'd1300, 32'h200007D0, IN2, 32'd300, 4'hF, 1'b1, 1'b0);

    // Large step (bit 31 set must be ignored) toward full scale; out0 saturates.
    w[0] = 32'h7FFFFFFF; w[4] = 32'hC0000000; apply_cfg();
    in_d[0*32 +: 32] = 32'h7FFFFFF0;
    t(SAT, 32'h200007D0, IN2, 32'h4000012C, 4'hE, 1'b1, 1'b0);
    t(SAT, 32'h200007D0, IN2, SAT,          4'hF, 1'b1, 1'b0);
    t(SAT, 32'h200007D0, IN2, SAT,          4'hF, 1'b1, 1'b0);

    // Head back to 0, then reset mid-ramp.
    w[0] = 32'd0; apply_cfg();
    t(SAT, 32'h200007D0, IN2, 32'h3FFFFFFF, 4'hE, 1'b1, 1'b0);
    #2 a_resetn = 1'b0;
    #1 chk_reset_state();
    for (int i = 0; i < 16; i++) w[i] = 32'd0;
    apply_cfg();
    sref = 32'd0;
    @(negedge a_clk);
    a_resetn = 1'b1;
    t(32'h7FFFFFF0, IN1, IN2, 32'd0, 4'hF, 1'b0, 1'b0);
    t(32'h7FFFFFF0, IN1, IN2, 32'd0, 4'hF, 1'b0, 1'b0);

    repeat (2) @(negedge a_clk);
    chk("queue_drained", sbq.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
